soc_system_led_sequencer: RTL and testbench
===========================================

// Module: soc_system_led_sequencer
// PURPOSE
//  Autonomous LED pattern player placed in front of the 7-bit LED PIO slave.
//  The host loads a pattern table and step period over a small Avalon-MM slave.
//  The block then issues single-cycle Avalon writes to PIO address 0, one per step, with optional looping.
//  The PIO stays a dumb output register; all timing and sequencing lives here.
// PARAMETERS
//  LED_W          7           width of pattern word / PIO out_port
//  DEPTH          16          pattern table entries (power of 2, 2..256)
//  DEFAULT_PERIOD 32'd50000000 PERIOD reset value (clk cycles per step)
//  OFF_PATTERN    7'h7F       word written to PIO on stop; equals PIO reset value
// PORTS
//  clk             in   1      system clock
//  reset           in   1      synchronous, active-high reset
//  address         in   3      config slave word address
//  chipselect      in   1      config slave select
//  write_n         in   1      config slave write strobe, active-low
//  writedata       in   32     config slave write data
//  readdata        out  32     config slave read data, combinational, zero wait
//  pio_address     out  2      to PIO; constant 0
//  pio_chipselect  out  1      to PIO; 1-cycle pulse per pattern write
//  pio_write_n     out  1      to PIO; low exactly when pio_chipselect high
//  pio_writedata   out  32     to PIO; {zeros, pattern[LED_W-1:0]}
//  busy            out  1      sequence running (mirrors STATUS.busy)
// BEHAVIOUR
//  Register map (write = chipselect & ~write_n):
//   0 CTRL    W: b0 START (self-clearing), b1 LOOP (sticky), b2 STOP (self-clearing); R: {30'b0,LOOP,1'b0}
//   1 STATUS  RO: b0 busy, b1 done (sticky), b[15:8] current index
//   2 PERIOD  RW 32b; value 0 treated as 1
//   3 LENGTH  RW [7:0] steps per pass; values > DEPTH clamp to DEPTH
//   4 TBL_PTR RW [log2(DEPTH)-1:0] table write pointer
//   5 TBL_DAT W: table[TBL_PTR] <= writedata[LED_W-1:0], TBL_PTR++ (wraps at DEPTH)
//     R: table[TBL_PTR], no increment
//   6,7 read 0, writes ignored
//  Reset: FSM IDLE, idx 0, busy 0, done 0, LOOP 0, PERIOD=DEFAULT_PERIOD, LENGTH 0, TBL_PTR 0
//   Reset also forces pio_chipselect 0, pio_write_n 1, pio_writedata 0; table contents are undefined.
//  FSM: IDLE, EMIT, HOLD, OFF
//   IDLE: START with LENGTH!=0 -> EMIT, idx=0, done=0, busy=1; START with LENGTH==0 ignored
//   EMIT (1 cycle): pio_chipselect=1, pio_write_n=0, pio_writedata=table[idx]; load cnt=PERIOD-1 -> HOLD
//   HOLD: cnt decrements each cycle; at cnt==0:
//     idx<LENGTH-1 -> idx++, EMIT
//     idx==LENGTH-1 & LOOP -> idx=0, EMIT
//     idx==LENGTH-1 & ~LOOP -> IDLE, busy=0, done=1 (last pattern stays on LEDs)
//   OFF (1 cycle): PIO write of OFF_PATTERN -> IDLE, busy=0, done unchanged
//  Timing: step spacing = max(PERIOD,1) cycles between consecutive EMIT pulses
//   First EMIT occurs the cycle after the START write.
//  STOP in any non-IDLE state -> OFF next cycle; STOP in IDLE also emits OFF (forces LEDs off)
//  START+STOP in same write: STOP wins
//  START while busy: restart, idx=0, EMIT next cycle, done cleared
//  PERIOD/LENGTH/table writes while busy: allowed, take effect at the next HOLD load / idx compare / EMIT read
//  LENGTH reduced below idx+1 while busy: pass ends at next HOLD expiry (idx>=LENGTH-1 test)
//  Reset asserted mid-sequence: immediate return to reset state; no OFF write is issued
//  pio_* outputs are registered; no back-pressure (PIO has no waitrequest)
// TESTING
//  T1 Load table {01,02,04}, LENGTH=3, PERIOD=4, START
//     -> PIO writes at cycles t+1, t+5, t+9 with 01, 02, 04; then done=1, busy=0
//  T2 Same as T1 with LOOP=1 -> 4th write at t+13 = 01; STOP at t+15 -> write 7F at t+16, busy=0, done=0
//  T3 PERIOD=0, LENGTH=2, table {55,2A} -> writes on consecutive cycles 55, 2A; done after 2 cycles
//  T4 LENGTH=0, START -> no PIO write, busy stays 0; LENGTH=200 with DEPTH=16 -> 16 writes then done
//  T5 START and STOP in one write while idle -> single 7F write, busy never 1
//  T6 TBL_PTR=15, two TBL_DAT writes -> entries 15 and 0 written, TBL_PTR=1
//  T6 cont. reset mid-HOLD -> pio_chipselect 0, PERIOD readback = DEFAULT_PERIOD

Source files
------------

// File: rtl/soc_system_led_sequencer.sv
// Autonomous LED pattern player: a host-loaded pattern table is replayed to the LED PIO
// as single-cycle Avalon writes, one per step period, with optional looping.
module soc_system_led_sequencer #(
    parameter int unsigned     LED_W          = 7,
    parameter int unsigned     DEPTH          = 16,
    parameter logic [31:0]     DEFAULT_PERIOD = 32'd50000000,
    parameter logic [LED_W-1:0] OFF_PATTERN   = 7'h7F
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [2:0]  address,
    input  logic        chipselect,
    input  logic        write_n,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic [1:0]  pio_address,
    output logic        pio_chipselect,
    output logic        pio_write_n,
    output logic [31:0] pio_writedata,
    output logic        busy
);

    localparam int unsigned IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned LW = 9;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EMIT = 2'd1,
        HOLD = 2'd2,
        OFF  = 2'd3
    } state_t;

    state_t            state, state_d;
    logic [IW-1:0]     idx, idx_d;
    logic [31:0]       cnt, cnt_d;
    logic              done, done_d;
    logic              busy_q, busy_d;
    logic              pio_cs_q, pio_cs_d;
    logic              pio_wn_q;
    logic [31:0]       pio_data_q, pio_data_d;
    logic              step;

    logic              loop_q;
    logic [31:0]       period_q;
    logic [7:0]        length_q;
    logic [IW-1:0]     tbl_ptr;
    logic [LED_W-1:0]  pat_mem [DEPTH];

    logic              wr, start, stop;
    logic [LW-1:0]     eff_len;
    logic [31:0]       per_eff;
    logic              last_step;

    assign wr        = chipselect & ~write_n;
    assign start     = wr && (address == 3'd0) && writedata[0];
    assign stop      = wr && (address == 3'd0) && writedata[2];
    assign eff_len   = (LW'(length_q) > LW'(DEPTH)) ? LW'(DEPTH) : LW'(length_q);
    assign per_eff   = (period_q == 32'd0) ? 32'd1 : period_q;
    // Written as >= so a LENGTH shrunk below the running index still ends the pass.
    assign last_step = (LW'(idx) + LW'(1)) >= eff_len;

    assign pio_address    = 2'd0;
    assign pio_chipselect = pio_cs_q;
    assign pio_write_n    = pio_wn_q;
    assign pio_writedata  = pio_data_q;
    assign busy           = busy_q;

    // Host configuration registers
    always_ff @(posedge clk) begin
        if (reset) begin
            loop_q   <= 1'b0;
            period_q <= DEFAULT_PERIOD;
            length_q <= 8'd0;
            tbl_ptr  <= '0;
        end else if (wr) begin
            case (address)
                3'd0: loop_q   <= writedata[1];
                3'd2: period_q <= writedata;
                3'd3: length_q <= writedata[7:0];
                3'd4: tbl_ptr  <= writedata[IW-1:0];
                3'd5: tbl_ptr  <= tbl_ptr + IW'(1);
                default: ;
            endcase
        end
    end

    // Pattern table storage, no reset
    always_ff @(posedge clk) begin
        if (wr && (address == 3'd5)) begin
            pat_mem[tbl_ptr] <= writedata[LED_W-1:0];
        end
    end

    always_comb begin
        readdata = 32'd0;
        case (address)
            3'd0: readdata = {30'd0, loop_q, 1'b0};
            3'd1: readdata = {16'd0, 8'(idx), 6'd0, done, busy_q};
            3'd2: readdata = period_q;
            3'd3: readdata = {24'd0, length_q};
            3'd4: readdata = 32'(tbl_ptr);
            3'd5: readdata = 32'(pat_mem[tbl_ptr]);
            default: readdata = 32'd0;
        endcase
    end

    // Sequencer state and registered PIO bus
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            idx        <= '0;
            cnt        <= 32'd0;
            done       <= 1'b0;
            busy_q     <= 1'b0;
            pio_cs_q   <= 1'b0;
            pio_wn_q   <= 1'b1;
            pio_data_q <= 32'd0;
        end else begin
            state      <= state_d;
            idx        <= idx_d;
            cnt        <= cnt_d;
            done       <= done_d;
            busy_q     <= busy_d;
            pio_cs_q   <= pio_cs_d;
            pio_wn_q   <= ~pio_cs_d;
            pio_data_q <= pio_data_d;
        end
    end

    // PIO strobes are computed from the next state so the write is on the bus during EMIT/OFF.
    always_comb begin
        state_d    = state;
        idx_d      = idx;
        cnt_d      = cnt;
        done_d     = done;
        busy_d     = busy_q;
        pio_cs_d   = 1'b0;
        pio_data_d = pio_data_q;
        step       = 1'b0;

        if (stop) begin
            state_d    = OFF;
            busy_d     = 1'b0;
            pio_cs_d   = 1'b1;
            pio_data_d = 32'(OFF_PATTERN);
        end else if (start && (length_q != 8'd0)) begin
            state_d    = EMIT;
            idx_d      = '0;
            done_d     = 1'b0;
            busy_d     = 1'b1;
            pio_cs_d   = 1'b1;
            pio_data_d = 32'(pat_mem[0]);
        end else begin
            case (state)
                EMIT: begin
                    cnt_d = per_eff - 32'd1;
                    if (per_eff == 32'd1) begin
                        step = 1'b1;
                    end else begin
                        state_d = HOLD;
                    end
                end
                HOLD: begin
                    cnt_d = cnt - 32'd1;
                    if (cnt <= 32'd1) begin
                        step = 1'b1;
                    end
                end
                OFF:     state_d = IDLE;
                default: ;
            endcase
        end

        // The EMIT cycle counts as the first cycle of the step period.
        if (step) begin
            if (!last_step) begin
                idx_d      = idx + IW'(1);
                state_d    = EMIT;
                pio_cs_d   = 1'b1;
                pio_data_d = 32'(pat_mem[idx + IW'(1)]);
            end else if (loop_q) begin
                idx_d      = '0;
                state_d    = EMIT;
                pio_cs_d   = 1'b1;
                pio_data_d = 32'(pat_mem[0]);
            end else begin
                state_d = IDLE;
                busy_d  = 1'b0;
                done_d  = 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_soc_system_led_sequencer.sv
// Bench for the LED sequencer: directed corner cases plus randomized sequences,
// each compared against a trace model of expected PIO writes (cycle, data).
module tb_soc_system_led_sequencer;

    localparam int unsigned NO_STOP = 32'hFFFF_FFFF;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic [1:0]  pio_address;
    logic        pio_chipselect;
    logic        pio_write_n;
    logic [31:0] pio_writedata;
    logic        busy;

    soc_system_led_sequencer dut (
        .clk            (clk),
        .reset          (reset),
        .address        (address),
        .chipselect     (chipselect),
        .write_n        (write_n),
        .writedata      (writedata),
        .readdata       (readdata),
        .pio_address    (pio_address),
        .pio_chipselect (pio_chipselect),
        .pio_write_n    (pio_write_n),
        .pio_writedata  (pio_writedata),
        .busy           (busy)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    int unsigned got_cyc[$];
    logic [31:0] got_dat[$];
    int unsigned exp_cyc[$];
    logic [31:0] exp_dat[$];
    logic [6:0]  tbl[16];
    bit          collect  = 1'b0;
    bit          saw_busy = 1'b0;

    // PIO bus monitor, sampled away from the active edge
    always @(negedge clk) begin
        if (collect) begin
            check("pio_write_n", 32'(pio_write_n), 32'(!pio_chipselect));
            if (pio_chipselect) begin
                got_cyc.push_back(cyc);
                got_dat.push_back(pio_writedata);
                check("pio_address", 32'(pio_address), 32'd0);
            end
            if (busy) saw_busy = 1'b1;
        end
    end

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        @(negedge clk);
        address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
        @(posedge clk);
        #1;
        chipselect = 1'b0; write_n = 1'b1;
    endtask

    task automatic rd(input logic [2:0] a, output logic [31:0] d);
        @(negedge clk);
        address = a; chipselect = 1'b1; write_n = 1'b1;
        #1;
        d = readdata;
        chipselect = 1'b0;
    endtask

    task automatic load_table(input int n);
        wr(3'd4, 32'd0);
        for (int i = 0; i < n; i++) wr(3'd5, 32'(tbl[i]));
    endtask

    // Program LENGTH/PERIOD, then START; ts is the monitor cycle of the first expected write
    task automatic start_seq(input int unsigned len, input int unsigned per, input bit lp,
                             output int unsigned ts);
        wr(3'd3, len);
        wr(3'd2, per);
        got_cyc.delete(); got_dat.delete();
        saw_busy = 1'b0;
        collect  = 1'b1;
        wr(3'd0, {30'd0, lp, 1'b1});
        ts = cyc;
    endtask

    // Expected trace: step k lands at ts + k*max(PERIOD,1) with table[k mod L]; STOP adds one 7F write
    task automatic build_exp(input int unsigned ts, input int unsigned len, input int unsigned per,
                             input bit lp, input int unsigned t_stop);
        int unsigned l, pe, c;
        l  = (len > 16) ? 16 : len;
        pe = (per == 0) ? 1 : per;
        exp_cyc.delete(); exp_dat.delete();
        for (int k = 0; k < 5000; k++) begin
            c = ts + k * pe;
            if (c >= t_stop) break;
            if (!lp && k >= l) break;
            exp_cyc.push_back(c);
            exp_dat.push_back(32'(tbl[k % l]));
        end
        if (t_stop != NO_STOP) begin
            exp_cyc.push_back(t_stop);
            exp_dat.push_back(32'h7F);
        end
    endtask

    task automatic compare_trace(input string tag);
        int n;
        check({tag, "_count"}, 32'(got_cyc.size()), 32'(exp_cyc.size()));
        n = (got_cyc.size() < exp_cyc.size()) ? got_cyc.size() : exp_cyc.size();
        for (int i = 0; i < n; i++) begin
            check($sformatf("%s_cyc%0d", tag, i), got_cyc[i], exp_cyc[i]);
            check($sformatf("%s_dat%0d", tag, i), got_dat[i], exp_dat[i]);
        end
    endtask

    initial begin
        int unsigned ts, t_stop, len, per, l, pe;
        bit          lp;
        logic [31:0] d;

        reset = 1'b1; address = 3'd0; chipselect = 1'b0; write_n = 1'b1; writedata = 32'd0;
        repeat (3) @(posedge clk);
        @(negedge clk) reset = 1'b0;

        // Reset state
        check("rst_pio_cs", 32'(pio_chipselect), 32'd0);
        check("rst_pio_wn", 32'(pio_write_n), 32'd1);
        check("rst_pio_data", pio_writedata, 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        rd(3'd2, d); check("rst_period", d, 32'd50000000);
        rd(3'd1, d); check("rst_status", d, 32'd0);
        rd(3'd3, d); check("rst_length", d, 32'd0);
        rd(3'd4, d); check("rst_tblptr", d, 32'd0);
        rd(3'd0, d); check("rst_ctrl", d, 32'd0);

        // Three-step pass, period 4
        tbl[0] = 7'h01; tbl[1] = 7'h02; tbl[2] = 7'h04;
        load_table(3);
        start_seq(3, 4, 1'b0, ts);
        repeat (20) @(posedge clk);
        build_exp(ts, 3, 4, 1'b0, NO_STOP);
        compare_trace("t1");
        rd(3'd1, d); check("t1_status", d, 32'h0000_0202);
        check("t1_busy", 32'(busy), 32'd0);

        // Looping pass stopped mid-hold
        start_seq(3, 4, 1'b1, ts);
        repeat (14) @(posedge clk);
        wr(3'd0, 32'h6);
        t_stop = cyc;
        repeat (4) @(posedge clk);
        build_exp(ts, 3, 4, 1'b1, t_stop);
        compare_trace("t2");
        rd(3'd1, d); check("t2_busy_done", d & 32'h3, 32'd0);
        rd(3'd0, d); check("t2_ctrl_loop", d, 32'h2);
        wr(3'd0, 32'd0);

        // PERIOD 0 behaves as 1
        tbl[0] = 7'h55; tbl[1] = 7'h2A;
        load_table(2);
        start_seq(2, 0, 1'b0, ts);
        repeat (6) @(posedge clk);
        build_exp(ts, 2, 0, 1'b0, NO_STOP);
        compare_trace("t3");
        rd(3'd1, d); check("t3_status", d, 32'h0000_0102);

        // LENGTH 0 start is ignored
        start_seq(0, 4, 1'b0, ts);
        repeat (8) @(posedge clk);
        check("t4_nowrite", 32'(got_cyc.size()), 32'd0);
        check("t4_busy", 32'(saw_busy), 32'd0);

        // LENGTH beyond DEPTH clamps to the full table
        for (int i = 0; i < 16; i++) tbl[i] = 7'($urandom_range(0, 127));
        load_table(16);
        start_seq(200, 1, 1'b0, ts);
        repeat (22) @(posedge clk);
        build_exp(ts, 200, 1, 1'b0, NO_STOP);
        compare_trace("t4_clamp");
        rd(3'd1, d); check("t4_status", d, 32'h0000_0F02);

        // START+STOP while idle: a lone off write, done left untouched
        got_cyc.delete(); got_dat.delete(); saw_busy = 1'b0;
        wr(3'd0, 32'h5);
        t_stop = cyc;
        repeat (4) @(posedge clk);
        build_exp(t_stop, 1, 1, 1'b0, t_stop);
        compare_trace("t5");
        check("t5_busy", 32'(saw_busy), 32'd0);
        rd(3'd1, d); check("t5_done", d & 32'h3, 32'h2);

        // Table pointer wrap
        wr(3'd4, 32'd15);
        wr(3'd5, 32'h11);
        wr(3'd5, 32'h22);
        rd(3'd4, d); check("t6_ptr", d, 32'd1);
        wr(3'd4, 32'd15);
        rd(3'd5, d); check("t6_ent15", d, 32'h11);
        wr(3'd4, 32'd0);
        rd(3'd5, d); check("t6_ent0", d, 32'h22);

        // Randomized sequences
        for (int it = 0; it < 10; it++) begin
            for (int i = 0; i < 16; i++) tbl[i] = 7'($urandom_range(0, 127));
            load_table(16);
            len = $urandom_range(1, 24);
            per = $urandom_range(0, 5);
            lp  = 1'($urandom_range(0, 1));
            l   = (len > 16) ? 16 : len;
            pe  = (per == 0) ? 1 : per;
            start_seq(len, per, lp, ts);
            if (lp) begin
                repeat ($urandom_range(3, 40)) @(posedge clk);
                wr(3'd0, 32'h6);
                t_stop = cyc;
                repeat (3) @(posedge clk);
                build_exp(ts, len, per, 1'b1, t_stop);
                compare_trace($sformatf("rnd%0d", it));
                rd(3'd1, d); check($sformatf("rnd%0d_status", it), d & 32'h3, 32'd0);
                wr(3'd0, 32'd0);
            end else begin
                repeat (l * pe + 4) @(posedge clk);
                build_exp(ts, len, per, 1'b0, NO_STOP);
                compare_trace($sformatf("rnd%0d", it));
                rd(3'd1, d);
                check($sformatf("rnd%0d_status", it), d, ((l - 1) << 8) | 32'h2);
            end
        end

        // Reset in the middle of a hold: no off write, registers back to defaults
        wr(3'd2, 32'd7);
        start_seq(2, 100, 1'b0, ts);
        repeat (10) @(posedge clk);
        @(negedge clk) reset = 1'b1;
        @(posedge clk);
        #1;
        check("rsth_pio_cs", 32'(pio_chipselect), 32'd0);
        check("rsth_pio_wn", 32'(pio_write_n), 32'd1);
        check("rsth_pio_data", pio_writedata, 32'd0);
        check("rsth_busy", 32'(busy), 32'd0);
        @(negedge clk) reset = 1'b0;
        repeat (5) @(posedge clk);
        check("rsth_writes", 32'(got_cyc.size()), 32'd1);
        rd(3'd2, d); check("rsth_period", d, 32'd50000000);
        rd(3'd1, d); check("rsth_status", d, 32'd0);
        collect = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
